// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; results are held until the next operation completes.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         overflow
);

  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic           a_bit, b_bit, d_bit, br_next;

  // Handshake: start is sampled only in IDLE; done pulses for one cycle when
  // diff/bout/overflow take their new values, which then hold until the next completion.
  always_comb begin
    a_bit   = a_sh_q[0];
    b_bit   = b_sh_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        res_d  = {d_bit, res_q[N-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // br_q is the borrow into the MSB here, br_next the borrow out of it.
          state_d = IDLE;
          diff_d  = res_d;
          bout_d  = br_next;
          ovf_d   = br_q ^ br_next;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule
